// File: rtl/bcd_display_feeder_pkg.sv
// bcd_display_feeder_pkg: shared FSM encoding and BCD widths
package bcd_display_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W   = 12;
  localparam int DIGIT_W = 4;
  localparam int ITER    = 8;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble adjust, adds 3 when the digit is 5 or more
module bcd_add3
  import bcd_display_feeder_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  always_comb d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;
endmodule

// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: 8-bit binary to 3-digit BCD converter with 7-segment refresh strobe
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic [7:0]       sw_out,
  output logic             toggle
);
  state_t                  state_q;
  logic [7:0]              bin_q;
  logic [BCD_W-1:0]        scr_q, bcd_q, adj_d;
  logic [2:0]              cnt_q;
  logic                    busy_q, done_q;
  logic [REFRESH_BITS-1:0] ref_q;
  logic [BCD_W+7:0]        sh_d;
  for (genvar g = 0; g < BCD_W / DIGIT_W; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(scr_q[g*DIGIT_W +: DIGIT_W]), .d_o(adj_d[g*DIGIT_W +: DIGIT_W]));
  end
  always_comb sh_d = {adj_d, bin_q} << 1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          bin_q   <= bin;
          scr_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {scr_q, bin_q} <= sh_d;
          cnt_q          <= cnt_q + 3'd1;
          state_q        <= (cnt_q == 3'(ITER - 1)) ? DONE : SHIFT;
        end
        DONE: begin
          bcd_q   <= scr_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // free-running display refresh, independent of the converter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ref_q <= '0;
    else     ref_q <= ref_q + REFRESH_BITS'(1);
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign bcd    = bcd_q;
  assign sw_out = bcd_q[7:0];
  assign toggle = ref_q[REFRESH_BITS-1];
endmodule

// File: tb/tb_bcd_display_feeder.sv
// tb_bcd_display_feeder: scoreboard bench with decimal-arithmetic reference model
module tb_bcd_display_feeder;
  logic        clk, rst, start, busy, done, toggle;
  logic [7:0]  bin, sw_out;
  logic [11:0] bcd;
  typedef struct {logic [11:0] b; int e;} exp_t;
  exp_t q[$];
  exp_t it;
  int   checks = 0, errors = 0;
  int   cyc = 0, free_at = 0, refcnt = 0;
  logic [11:0] last = '0;
  bcd_display_feeder #(.REFRESH_BITS(3)) dut (
    .clk(clk), .rst(rst), .bin(bin), .start(start), .busy(busy),
    .done(done), .bcd(bcd), .sw_out(sw_out), .toggle(toggle)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // a start is accepted only when the converter is free; result due nine edges later
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      free_at = 0;
      refcnt  = 0;
    end else begin
      refcnt = (refcnt + 1) % 8;
      if (start && cyc >= free_at) begin
        q.push_back('{ref_bcd(int'(bin)), cyc + 9});
        free_at = cyc + 10;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      last = '0;
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bcd", bcd, 0);
      chk("rst_sw_out", sw_out, 0);
      chk("rst_toggle", toggle, 0);
    end else begin
      chk("toggle", toggle, (refcnt >> 2) & 1);
      chk("busy", busy, (q.size() > 0 && cyc < q[0].e) ? 1 : 0);
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          it = q.pop_front();
          chk("done_cycle", cyc, it.e);
          last = it.b;
        end
      end else if (q.size() > 0 && cyc > q[0].e) begin
        chk("missed_done", 0, 1);
        void'(q.pop_front());
      end
      chk("bcd", bcd, last);
      chk("sw_out", sw_out, last[7:0]);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    #1 start = 1; bin = v;
    @(negedge clk);
    #1 start = 0; bin = $urandom;
  endtask
  initial begin
    int seq[4] = '{0, 99, 100, 59};
    rst = 0; start = 0; bin = 0;
    #1 rst = 1;
    idle(3);
    #1 rst = 0;
    pulse(8'd255); idle(12);
    foreach (seq[i]) begin pulse(8'(seq[i])); idle(10); end
    pulse(8'd37); idle(2); pulse(8'd11); idle(5); pulse(8'd22); idle(12);
    pulse(8'd200); idle(3);
    #1 rst = 1;
    @(negedge clk);
    #1 rst = 0;
    idle(2);
    pulse(8'd200); idle(12);
    @(negedge clk);
    #1 start = 1;
    repeat (60) begin bin = $urandom; @(negedge clk); #1; end
    start = 0;
    idle(12);
    for (int v = 0; v < 256; v++) begin pulse(8'(v)); idle(9); end
    repeat (1500) begin
      @(negedge clk);
      #1 start = ($urandom_range(0, 3) == 0); bin = $urandom;
    end
    start = 0;
    idle(12);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
